pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter register and fetch sequencer for the tp4 pipelined MIPS.
- Consumes the next-PC selection (sequential PC+4 vs. redirect target) and holds the architectural PC.
- Drives the instruction-memory address and the IF/ID enable.
- Obeys debug-unit run/step/halt control, and counts advanced instructions for the debug dump.

Parameters:
- BUS_WIDTH, 32, width of PC, targets and counter.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  debug-unit pulse; leaves IDLE.
- step_mode  input  1  sampled with start: 1 = STEP, 0 = RUN.
- step_pulse  input  1  one-cycle pulse; advances one instruction in STEP.
- stall  input  1  load-use hazard; hold PC.
- redirect_valid  input  1  branch/jump taken (mux select).
- redirect_pc  input  BUS_WIDTH  branch/jump target.
- halt_in  input  1  HALT opcode decoded for current fetch.
- pc_out  output  BUS_WIDTH  current PC / instruction memory address.
- pc_plus4  output  BUS_WIDTH  pc_out+PC_INC, forwarded for link/branch calc.
- fetch_en  output  1  IF/ID latch enable this cycle.
- halted  output  1  sticky halt flag.
- align_err  output  1  sticky misaligned-redirect flag.
- instr_count  output  BUS_WIDTH  number of PC advances since reset.

Behaviour:
- Reset (rst_n=0, async):
  - pc_out=RESET_PC, pc_plus4=RESET_PC+PC_INC.
  - fetch_en=0, halted=0, align_err=0, instr_count=0, state=IDLE.
- States: IDLE, RUN, STEP, HALTED (2-bit encoding, registered).
- IDLE:
  - start=1 moves to STEP if step_mode=1, else RUN.
  - No advance in the cycle of transition.
- adv (combinational):
  - adv = (state==RUN | (state==STEP & step_pulse)) & !halt_in & (!stall | redirect_valid).
  - fetch_en = adv.
- Priority, highest first: halt_in, redirect_valid, stall, increment.
  - Redirect overrides stall (control flush wins over load-use hold).
- On clock edge with adv:
  - If redirect_valid: pc_out <= {redirect_pc[W-1:2],2'b00}; align_err <= 1 if redirect_pc[1:0]!=0.
  - Otherwise: pc_out <= pc_out+PC_INC, modulo 2^BUS_WIDTH (0xFFFFFFFC wraps to 0x00000000).
  - pc_plus4 is registered alongside pc_out, always equal to pc_out+PC_INC mod 2^W.
  - instr_count <= instr_count+1, saturating at all-ones.
- halt_in=1 in RUN, or in STEP with step_pulse:
  - PC holds and state moves to HALTED.
  - halted=1 from the next cycle; fetch_en=0.
- HALTED:
  - Terminal until rst_n.
  - All inputs ignored; PC and counter frozen.
- STEP without step_pulse: PC holds, fetch_en=0.
  - step_pulse coincident with stall and no redirect is consumed: no advance, and no retry on later cycles.
- step_pulse and start in IDLE: the step_pulse is ignored.
- Async reset mid-operation: immediate return to reset values, regardless of state or pending step.
- No combinational path from redirect_pc to pc_out; single-cycle update latency.

Decomposition:
- Shared include pc_defs.vh:
  - state encodings ST_IDLE, ST_RUN, ST_STEP, ST_HALTED;
  - PC_INC default;
  - RESET_PC default.
- The existing 2:1 PC mux is reused for the redirect/increment select (mux_select=redirect_valid, mux1_in=pc+4, mux2_in=aligned target).
- No further sub-module; the FSM, PC register and counter stay in pc_unit.

Test Plan:
- Reset, start with step_mode=0, 5 idle cycles -> pc_out 0,4,8,12,16; instr_count=5; fetch_en=1 each advancing cycle.
- RUN at pc=0x40, stall=1 for 2 cycles -> pc_out stays 0x40, fetch_en=0, instr_count unchanged; then resumes at 0x44.
- RUN with stall=1 and redirect_valid=1, redirect_pc=0x100 -> pc_out=0x100 next cycle, instr_count+1; then redirect_pc=0x203 -> pc_out=0x200, align_err=1 (sticky).
- STEP mode: 3 step_pulse separated by idle cycles -> pc_out 0,4,8,12 changing only after each pulse; fetch_en high only in pulse cycles.
- halt_in=1 at pc=0x20 in RUN -> pc_out stays 0x20, halted=1 next cycle, later step_pulse/redirect ignored; rst_n low -> pc_out=0, halted=0, state IDLE.
- pc_out=0xFFFFFFFC (preloaded via redirect) with increment -> pc_out=0x00000000, pc_plus4=0x00000004.

Source files
------------

// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_pkg
// Description : Shared definitions for the tp4 MIPS program-counter unit:
//               sequencer state encoding and default PC constants.
// Contents    : pc_state_t   - 2-bit sequencer state (IDLE/RUN/STEP/HALTED)
//               DEF_PC_INC   - default sequential increment in bytes
//               DEF_RESET_PC - default PC loaded on reset
// Revision    : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } pc_state_t;

   localparam int          DEF_PC_INC   = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_unit_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_mux
// Description : 2:1 next-PC multiplexer (sequential vs. redirect target).
// Ports       : mux_select - 0 selects mux1_in, 1 selects mux2_in
//               mux1_in    - sequential PC (pc + increment)
//               mux2_in    - aligned redirect target
//               mux_out    - selected next PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit_mux #(
   parameter int BUS_WIDTH = 32
) (
   input  logic                 mux_select,
   input  logic [BUS_WIDTH-1:0] mux1_in,
   input  logic [BUS_WIDTH-1:0] mux2_in,
   output logic [BUS_WIDTH-1:0] mux_out
);

   assign mux_out = mux_select ? mux2_in : mux1_in;

endmodule : pc_unit_mux
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter register and fetch sequencer for the tp4
//               pipelined MIPS. Holds the architectural PC, selects between
//               sequential and redirect next-PC, drives the IF/ID enable and
//               obeys debug-unit run/step/halt control.
// Ports       : clk, rst_n       - clock (rising edge), async active-low reset
//               start, step_mode - leave IDLE into STEP (1) or RUN (0)
//               step_pulse       - advance one instruction while in STEP
//               stall            - load-use hold
//               redirect_valid,
//               redirect_pc      - taken branch/jump and its target
//               halt_in          - HALT decoded for the current fetch
//               pc_out, pc_plus4 - current PC and PC + increment
//               fetch_en         - IF/ID enable this cycle
//               halted,align_err - sticky status flags
//               instr_count      - saturating count of PC advances
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int                   BUS_WIDTH = 32,
   parameter logic [BUS_WIDTH-1:0] RESET_PC  = BUS_WIDTH'(DEF_RESET_PC),
   parameter int                   PC_INC    = DEF_PC_INC
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 step_mode,
   input  logic                 step_pulse,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [BUS_WIDTH-1:0] redirect_pc,
   input  logic                 halt_in,
   output logic [BUS_WIDTH-1:0] pc_out,
   output logic [BUS_WIDTH-1:0] pc_plus4,
   output logic                 fetch_en,
   output logic                 halted,
   output logic                 align_err,
   output logic [BUS_WIDTH-1:0] instr_count
);

   localparam logic [BUS_WIDTH-1:0] INC     = BUS_WIDTH'(PC_INC);
   localparam logic [BUS_WIDTH-1:0] CNT_ONE = BUS_WIDTH'(1);

   pc_state_t            state;
   pc_state_t            state_nxt;
   logic                 active;
   logic                 adv;
   logic                 halt_take;
   logic [BUS_WIDTH-1:0] aligned_target;
   logic [BUS_WIDTH-1:0] pc_next;

   // A cycle is "active" when the sequencer would fetch: free-running RUN,
   // or STEP with the pulse present. A pulse that lands on a stall is simply
   // lost, since nothing remembers it.
   assign active    = (state == ST_RUN) | ((state == ST_STEP) & step_pulse);
   assign halt_take = active & halt_in;
   // Redirect beats stall: a control flush must not be held by load-use.
   assign adv       = active & ~halt_in & (~stall | redirect_valid);
   assign fetch_en  = adv;
   assign halted    = (state == ST_HALTED);

   assign aligned_target = {redirect_pc[BUS_WIDTH-1:2], 2'b00};

   pc_unit_mux #(
      .BUS_WIDTH (BUS_WIDTH)
   ) u_pc_mux (
      .mux_select (redirect_valid),
      .mux1_in    (pc_plus4),
      .mux2_in    (aligned_target),
      .mux_out    (pc_next)
   );

   // ---------------------------------------------------------------------
   // Sequencer state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = step_mode ? ST_STEP : ST_RUN;
            end
         end
         ST_RUN, ST_STEP: begin
            if (halt_take) begin
               state_nxt = ST_HALTED;
            end
         end
         ST_HALTED: begin
            state_nxt = ST_HALTED;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // PC, PC+increment, sticky alignment flag and advance counter.
   // pc_plus4 is registered with pc_out so the sequential mux input never
   // sits behind an adder on the fetch path.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_out      <= RESET_PC;
         pc_plus4    <= RESET_PC + INC;
         align_err   <= 1'b0;
         instr_count <= '0;
      end else if (adv) begin
         pc_out   <= pc_next;
         pc_plus4 <= pc_next + INC;
         if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            align_err <= 1'b1;
         end
         if (instr_count != '1) begin
            instr_count <= instr_count + CNT_ONE;
         end
      end
   end

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit. Inputs change 1 ns
//               after a rising edge; fetch_en is checked before the next
//               edge and registered outputs 1 ns after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, step_mode, step_pulse, stall, redirect_valid, halt_in;
   logic [31:0] redirect_pc;
   logic [31:0] pc_out, pc_plus4, instr_count;
   logic        fetch_en, halted, align_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .step_mode      (step_mode),
      .step_pulse     (step_pulse),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_in        (halt_in),
      .pc_out         (pc_out),
      .pc_plus4       (pc_plus4),
      .fetch_en       (fetch_en),
      .halted         (halted),
      .align_err      (align_err),
      .instr_count    (instr_count)
   );

   task automatic clear_inputs();
      start = 0; step_mode = 0; step_pulse = 0; stall = 0;
      redirect_valid = 0; redirect_pc = '0; halt_in = 0;
   endtask

   // Advance past the next rising edge, ending 1 ns after it.
   task automatic edge1();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      #12;
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
      checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h exp %h", pc_plus4, 32'h4); end
      checks++; if ({fetch_en, halted, align_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {fetch_en, halted, align_err}); end
      checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", instr_count); end
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_run();
      start = 1; step_mode = 0; #1;
      checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL start_no_fetch got %b exp 0", fetch_en); end
      edge1();
      start = 0;
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL start_pc got %h exp 0", pc_out); end
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (pc_out !== 32'(4 * i)) begin errors++; $display("FAIL run_pc[%0d] got %h exp %h", i, pc_out, 32'(4 * i)); end
         checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL run_fetch[%0d] got %b exp 1", i, fetch_en); end
         edge1();
      end
      checks++; if (pc_out !== 32'd20) begin errors++; $display("FAIL run_pc_end got %h exp %h", pc_out, 32'd20); end
      checks++; if (instr_count !== 32'd5) begin errors++; $display("FAIL run_cnt got %0d exp 5", instr_count); end
   endtask

   task automatic test_stall();
      redirect_valid = 1; redirect_pc = 32'h40;
      edge1();
      redirect_valid = 0; stall = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL stall_fetch[%0d] got %b exp 0", i, fetch_en); end
         edge1();
         checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 40", i, pc_out); end
         checks++; if (instr_count !== 32'd6) begin errors++; $display("FAIL stall_cnt[%0d] got %0d exp 6", i, instr_count); end
      end
      stall = 0;
      edge1();
      checks++; if (pc_out !== 32'h44) begin errors++; $display("FAIL stall_resume got %h exp 44", pc_out); end
      checks++; if (instr_count !== 32'd7) begin errors++; $display("FAIL stall_resume_cnt got %0d exp 7", instr_count); end
   endtask

   task automatic test_redirect();
      stall = 1; redirect_valid = 1; redirect_pc = 32'h100; #1;
      checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL redir_stall_fetch got %b exp 1", fetch_en); end
      edge1();
      checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL redir_pc got %h exp 100", pc_out); end
      checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL redir_pc4 got %h exp 104", pc_plus4); end
      checks++; if (instr_count !== 32'd8) begin errors++; $display("FAIL redir_cnt got %0d exp 8", instr_count); end
      checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL redir_align0 got %b exp 0", align_err); end
      stall = 0; redirect_pc = 32'h203;
      edge1();
      checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL misalign_pc got %h exp 200", pc_out); end
      checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL misalign_flag got %b exp 1", align_err); end
      redirect_valid = 0;
      edge1();
      checks++; if (pc_out !== 32'h204) begin errors++; $display("FAIL post_redir_pc got %h exp 204", pc_out); end
      checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sticky got %b exp 1", align_err); end
      checks++; if (instr_count !== 32'd10) begin errors++; $display("FAIL post_redir_cnt got %0d exp 10", instr_count); end
   endtask

   task automatic test_wrap();
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
      edge1();
      redirect_valid = 0;
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pre_pc4 got %h exp 0", pc_plus4); end
      edge1();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc_out); end
      checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_pc4 got %h exp 4", pc_plus4); end
      checks++; if (instr_count !== 32'd12) begin errors++; $display("FAIL wrap_cnt got %0d exp 12", instr_count); end
   endtask

   task automatic test_halt();
      redirect_valid = 1; redirect_pc = 32'h20;
      edge1();
      redirect_valid = 0; halt_in = 1; #1;
      checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL halt_fetch got %b exp 0", fetch_en); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", halted); end
      edge1();
      halt_in = 0;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
      checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL halt_pc got %h exp 20", pc_out); end
      step_pulse = 1; redirect_valid = 1; redirect_pc = 32'h80; start = 1; #1;
      checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL halted_fetch got %b exp 0", fetch_en); end
      edge1(); edge1();
      checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL halted_pc got %h exp 20", pc_out); end
      checks++; if (instr_count !== 32'd13) begin errors++; $display("FAIL halted_cnt got %0d exp 13", instr_count); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky got %b exp 1", halted); end
      // Asynchronous reset, asserted away from any clock edge.
      clear_inputs();
      #2 rst_n = 0; #1;
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL areset_pc got %h exp 0", pc_out); end
      checks++; if ({halted, align_err} !== 2'b00) begin errors++; $display("FAIL areset_flags got %b exp 00", {halted, align_err}); end
      checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", instr_count); end
      edge1();
      rst_n = 1;
   endtask

   task automatic test_step();
      // step_pulse alongside start in IDLE must not advance.
      start = 1; step_mode = 1; step_pulse = 1;
      edge1();
      start = 0; step_mode = 0; step_pulse = 0;
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL step_entry_pc got %h exp 0", pc_out); end
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL step_idle_fetch[%0d] got %b exp 0", i, fetch_en); end
         edge1();
         checks++; if (pc_out !== 32'(4 * i)) begin errors++; $display("FAIL step_hold[%0d] got %h exp %h", i, pc_out, 32'(4 * i)); end
         step_pulse = 1; #1;
         checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL step_fetch[%0d] got %b exp 1", i, fetch_en); end
         edge1();
         step_pulse = 0;
         checks++; if (pc_out !== 32'(4 * (i + 1))) begin errors++; $display("FAIL step_pc[%0d] got %h exp %h", i, pc_out, 32'(4 * (i + 1))); end
      end
      // Pulse swallowed by stall, never retried.
      step_pulse = 1; stall = 1;
      edge1();
      step_pulse = 0; stall = 0;
      edge1();
      checks++; if (pc_out !== 32'd12) begin errors++; $display("FAIL step_stall_pc got %h exp c", pc_out); end
      checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL step_stall_cnt got %0d exp 3", instr_count); end
   endtask

   task automatic test_back_to_back();
      step_pulse = 1;
      edge1();
      checks++; if (pc_out !== 32'd16) begin errors++; $display("FAIL b2b_pc0 got %h exp 10", pc_out); end
      edge1();
      step_pulse = 0;
      checks++; if (pc_out !== 32'd20) begin errors++; $display("FAIL b2b_pc1 got %h exp 14", pc_out); end
      checks++; if (instr_count !== 32'd5) begin errors++; $display("FAIL b2b_cnt got %0d exp 5", instr_count); end
      // Halt in STEP only takes effect with a pulse.
      halt_in = 1;
      edge1();
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step_halt_nopulse got %b exp 0", halted); end
      step_pulse = 1;
      edge1();
      step_pulse = 0; halt_in = 0;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_halt got %b exp 1", halted); end
      checks++; if (pc_out !== 32'd20) begin errors++; $display("FAIL step_halt_pc got %h exp 14", pc_out); end
   endtask

   initial begin
      test_reset();
      test_run();
      test_stall();
      test_redirect();
      test_wrap();
      test_halt();
      test_step();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pc_unit
`default_nettype wire
